anim_sequencer: RTL and testbench

//   Timebase and control stage feeding the 7-segment animation decoder.
//   - Debounces btnC and advances the animation mode on each accepted press.
//   - Generates a millisecond count and a digit-scan position for the decoder.
//   - Outputs drive update7segment's millis/mode/pos inputs directly.

---
 rtl/anim_sequencer.sv | 149 ++++++++++++++
 tb/tb_anim_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// Timebase and button-control stage for the 7-segment animation decoder.
// It debounces btnC, and each accepted press advances the animation mode.
// It also produces the millisecond count and the digit-scan position.
module anim_sequencer #(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned MODE_INIT       = 2,
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned MILLIS_W        = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btnC,
  output logic [MILLIS_W-1:0] millis,
  output logic [31:0]         mode,
  output logic [31:0]         pos,
  output logic                tick_ms,
  output logic                mode_strobe
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic               sync1;
  logic               btn_s;
  logic [PRESC_W-1:0] presc;
  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               press_c;
  logic               tick_c;

  assign tick_c = (presc == PRESC_W'(TICK_DIV - 1));

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btnC;
      btn_s <= sync1;
    end
  end

  // Debounce FSM state and stability counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce next-state logic. A press is accepted on the cycle the FSM enters HELD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_c   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press_c   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Millisecond prescaler. It restarts on a press so the first tick of a new mode comes a full period later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (press_c || tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Output registers. A press takes priority over a tick on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      millis      <= '0;
      mode        <= 32'(MODE_INIT);
      pos         <= '0;
      tick_ms     <= 1'b0;
      mode_strobe <= 1'b0;
    end else begin
      tick_ms     <= 1'b0;
      mode_strobe <= 1'b0;
      if (press_c) begin
        mode        <= (mode == 32'(NUM_MODES - 1)) ? 32'd0 : mode + 32'd1;
        millis      <= '0;
        pos         <= '0;
        mode_strobe <= 1'b1;
      end else if (tick_c) begin
        millis  <= millis + MILLIS_W'(1);
        pos     <= (pos == 32'(NUM_DIGITS - 1)) ? 32'd0 : pos + 32'd1;
        tick_ms <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer using small timing parameters.
// A run-length debounce model and a tick counter model supply the expected outputs.
module tb_anim_sequencer;

  localparam int unsigned TD = 5;
  localparam int unsigned DB = 4;
  localparam int unsigned NM = 4;
  localparam int unsigned MI = 2;
  localparam int unsigned ND = 8;
  localparam int unsigned MW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btnC;
  logic [MW-1:0] millis;
  logic [31:0]   mode;
  logic [31:0]   pos;
  logic          tick_ms;
  logic          mode_strobe;

  int n_pass  = 0;
  int n_total = 0;

  anim_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .NUM_MODES(NM),
    .MODE_INIT(MI), .NUM_DIGITS(ND), .MILLIS_W(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btnC(btnC), .millis(millis), .mode(mode),
    .pos(pos), .tick_ms(tick_ms), .mode_strobe(mode_strobe)
  );

  always #5 clk = ~clk;

  // Reference model. The debounced level flips once btn_s has differed from it for DB+1 consecutive edges.
  // millis is the number of whole TD-cycle periods elapsed since the last reset or press.
  logic            m_s1, m_s2, m_deb, m_press, m_tick, m_strobe;
  int unsigned     m_run;
  longint unsigned m_k;
  logic [63:0]     m_millis;
  int unsigned     m_mode;
  logic [129:0]    exp_vec;
  logic [129:0]    act_vec;

  assign act_vec = {millis, mode, pos, tick_ms, mode_strobe};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0; m_run = 0; m_k = 0;
      m_mode = MI; m_millis = 64'd0; m_tick = 1'b0; m_strobe = 1'b0;
    end else begin
      m_press = 1'b0;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_deb   = m_s2;
          m_run   = 0;
          m_press = m_s2;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btnC;
      m_k++;
      if (m_press) begin
        m_mode = (m_mode + 1) % NM; m_k = 0; m_millis = 64'd0;
        m_tick = 1'b0; m_strobe = 1'b1;
      end else begin
        m_strobe = 1'b0;
        m_tick = ((m_k % TD) == 0);
        if (m_tick) m_millis++;
      end
    end
    exp_vec = {m_millis, 32'(m_mode), 32'(m_millis % 64'(ND)), m_tick, m_strobe};
  end

  // Drive btnC before the next rising edge and return at the following falling edge.
  task automatic step(input logic b);
    btnC = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btnC  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btnC  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (act_vec !== {64'd0, 32'd2, 32'd0, 2'b00})
      $display("FAIL reset_values: got %h exp %h", act_vec, {64'd0, 32'd2, 32'd0, 2'b00});
    else n_pass++;
    n_total++;
    if (act_vec !== exp_vec) $display("FAIL reset_model: got %h exp %h", act_vec, exp_vec);
    else n_pass++;
    rst_n = 1'b1;
    btnC  = 1'b0;
  endtask

  task automatic test_idle_ticks();
    int ticks = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (tick_ms === 1'b1) ticks++;
      n_total++;
      if (act_vec !== exp_vec) $display("FAIL idle_model cyc %0d: got %h exp %h", i, act_vec, exp_vec);
      else n_pass++;
    end
    n_total++;
    if (ticks != 8 || millis !== 64'd8 || pos !== 32'd0 || mode !== 32'd2)
      $display("FAIL idle_summary: ticks=%0d millis=%0d pos=%0d mode=%0d exp 8/8/0/2", ticks, millis, pos, mode);
    else n_pass++;
  endtask

  task automatic test_single_press();
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      step(i <= 12);
      n_total++;
      if (act_vec !== exp_vec) $display("FAIL press_model cyc %0d: got %h exp %h", i, act_vec, exp_vec);
      else n_pass++;
      if (i == 6) begin
        n_total++;
        if (mode !== 32'd2 || mode_strobe !== 1'b0)
          $display("FAIL press_early: mode=%0d strobe=%b exp 2/0", mode, mode_strobe);
        else n_pass++;
      end
      if (i == 7) begin
        n_total++;
        if (mode !== 32'd3 || millis !== 64'd0 || pos !== 32'd0 || mode_strobe !== 1'b1)
          $display("FAIL press_edge7: mode=%0d millis=%0d pos=%0d strobe=%b exp 3/0/0/1", mode, millis, pos, mode_strobe);
        else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if (mode !== 32'd3 || mode_strobe !== 1'b0)
          $display("FAIL press_after: mode=%0d strobe=%b exp 3/0", mode, mode_strobe);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    int exp_modes [4] = '{3, 0, 1, 2};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(i < 10);
        n_total++;
        if (act_vec !== exp_vec) $display("FAIL wrap_model p%0d cyc %0d: got %h exp %h", p, i, act_vec, exp_vec);
        else n_pass++;
      end
      n_total++;
      if (mode !== 32'(exp_modes[p])) $display("FAIL wrap_mode p%0d: got %0d exp %0d", p, mode, exp_modes[p]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int strobes = 0;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 6; i++) begin
        step(i < 3);
        if (mode_strobe === 1'b1) strobes++;
        n_total++;
        if (act_vec !== exp_vec) $display("FAIL glitch_model r%0d cyc %0d: got %h exp %h", r, i, act_vec, exp_vec);
        else n_pass++;
      end
    end
    n_total++;
    if (strobes != 0 || mode !== 32'd2) $display("FAIL glitch_reject: strobes=%0d mode=%0d exp 0/2", strobes, mode);
    else n_pass++;
  endtask

  task automatic test_long_hold();
    int strobes = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 110; i++) begin
        step(i < 100);
        if (mode_strobe === 1'b1) strobes++;
        n_total++;
        if (act_vec !== exp_vec) $display("FAIL hold_model r%0d cyc %0d: got %h exp %h", r, i, act_vec, exp_vec);
        else n_pass++;
      end
    end
    n_total++;
    if (strobes != 2 || mode !== 32'd0) $display("FAIL hold_count: strobes=%0d mode=%0d exp 2/0", strobes, mode);
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    rst_n = 1'b0;
    btnC  = 1'b0;
    @(negedge clk);
    n_total++;
    if (mode !== 32'd2 || millis !== 64'd0 || mode_strobe !== 1'b0)
      $display("FAIL midreset_values: mode=%0d millis=%0d strobe=%b exp 2/0/0", mode, millis, mode_strobe);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (mode_strobe === 1'b1) strobes++;
      n_total++;
      if (act_vec !== exp_vec) $display("FAIL midreset_model cyc %0d: got %h exp %h", i, act_vec, exp_vec);
      else n_pass++;
    end
    n_total++;
    if (strobes != 0 || mode !== 32'd2) $display("FAIL midreset_discard: strobes=%0d mode=%0d exp 0/2", strobes, mode);
    else n_pass++;
  endtask

  task automatic test_press_tick_align();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 1; i <= 24; i++) begin
      step(i <= 14);
      n_total++;
      if (act_vec !== exp_vec) $display("FAIL align_model cyc %0d: got %h exp %h", i, act_vec, exp_vec);
      else n_pass++;
      if (i == 7) begin
        n_total++;
        if (millis !== 64'd0 || tick_ms !== 1'b0 || mode !== 32'd3 || mode_strobe !== 1'b1)
          $display("FAIL align_press: millis=%0d tick=%b mode=%0d strobe=%b exp 0/0/3/1", millis, tick_ms, mode, mode_strobe);
        else n_pass++;
      end
      if (i == 11) begin
        n_total++;
        if (millis !== 64'd0 || tick_ms !== 1'b0)
          $display("FAIL align_pretick: millis=%0d tick=%b exp 0/0", millis, tick_ms);
        else n_pass++;
      end
      if (i == 12) begin
        n_total++;
        if (millis !== 64'd1 || tick_ms !== 1'b1)
          $display("FAIL align_tick: millis=%0d tick=%b exp 1/1", millis, tick_ms);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int   run_left = 0;
    logic lvl      = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        lvl      = ~lvl;
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      rst_n = ($urandom_range(0, 299) != 0);
      step(lvl);
      n_total++;
      if (act_vec !== exp_vec) $display("FAIL random_model cyc %0d: got %h exp %h", i, act_vec, exp_vec);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    btnC  = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_ticks();
    test_single_press();
    test_wrap();
    test_glitch();
    test_long_hold();
    test_reset_mid_press();
    test_press_tick_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
